// File: rtl/cpu_oci_dct_packer.sv
// OCI direct-branch trace (DCT) packer.
// Packs 2-bit branch codes into a 15-slot buffer. Full or flushed buffers move into a
// one-entry holding register that feeds a valid/ready link to the trace memory writer.
// At end of test the packer drains and then reports completion.
module cpu_oci_dct_packer #(
  parameter int unsigned CODE_W = 2,
  parameter int unsigned SLOTS  = 15
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  trc_on,
  input  logic                                  code_valid,
  input  logic [CODE_W-1:0]                     code,
  input  logic                                  flush_req,
  input  logic                                  test_ending,
  output logic [CODE_W*SLOTS-1:0]               dct_buffer,
  output logic [$clog2(SLOTS+1)-1:0]            dct_count,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [$clog2(SLOTS+1)+CODE_W*SLOTS-1:0] out_data,
  output logic                                  overflow,
  output logic                                  test_has_ended
);

  localparam int unsigned BUF_W = CODE_W * SLOTS;
  localparam int unsigned CNT_W = $clog2(SLOTS + 1);
  localparam int unsigned OUT_W = CNT_W + BUF_W;
  localparam logic [CNT_W-1:0] FullCnt = CNT_W'(SLOTS);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StEnded} state_e;

  state_e            r_state, w_state_d;
  logic [BUF_W-1:0]  r_buf, w_buf_d;
  logic [CNT_W-1:0]  r_cnt, w_cnt_d;
  logic              r_out_valid, w_out_valid_d;
  logic [OUT_W-1:0]  r_out_data, w_out_data_d;
  logic              r_overflow, w_overflow_d;
  logic              r_flush_pend, w_flush_pend_d;

  logic              w_accept;
  logic              w_hold_free;
  logic              w_to_drain;
  logic              w_flush;
  logic [BUF_W-1:0]  w_nbuf;
  logic [CNT_W-1:0]  w_ncnt;

  // Packing, transfer into the holding register, overflow and flush tracking.
  always_comb begin
    w_accept    = (r_state == StRun) && trc_on && code_valid;
    // Holding register can take a new word when empty or being consumed this cycle.
    w_hold_free = !r_out_valid || out_ready;
    w_to_drain  = test_ending && ((r_state == StRun) || (r_state == StIdle));
    // Pending flushes, drain entry and drain state all ask for the partial buffer.
    w_flush     = r_flush_pend || w_to_drain || (r_state == StDrain) ||
                  ((r_state == StRun) && flush_req);
    w_nbuf      = w_accept ? {r_buf[BUF_W-CODE_W-1:0], code} : r_buf;
    w_ncnt      = r_cnt + CNT_W'(w_accept);

    w_buf_d        = r_buf;
    w_cnt_d        = r_cnt;
    w_overflow_d   = r_overflow;
    w_flush_pend_d = r_flush_pend;
    w_out_valid_d  = r_out_valid && !out_ready;
    w_out_data_d   = r_out_data;

    if (r_cnt == FullCnt) begin
      // A full buffer waiting for the holding register also satisfies any flush.
      w_flush_pend_d = 1'b0;
      if (w_hold_free) begin
        w_out_valid_d = 1'b1;
        w_out_data_d  = {FullCnt, r_buf};
        w_buf_d       = w_accept ? BUF_W'(code) : '0;
        w_cnt_d       = w_accept ? CNT_W'(1) : '0;
      end else if (w_accept) begin
        w_overflow_d = 1'b1;
      end
    end else if ((w_ncnt == FullCnt) || (w_flush && (w_ncnt != '0))) begin
      if (w_hold_free) begin
        w_out_valid_d  = 1'b1;
        w_out_data_d   = {w_ncnt, w_nbuf};
        w_buf_d        = '0;
        w_cnt_d        = '0;
        w_flush_pend_d = 1'b0;
      end else begin
        w_buf_d        = w_nbuf;
        w_cnt_d        = w_ncnt;
        w_flush_pend_d = w_flush;
      end
    end else begin
      // Nothing to emit; a flush with an empty buffer simply collapses.
      w_buf_d        = w_nbuf;
      w_cnt_d        = w_ncnt;
      w_flush_pend_d = 1'b0;
    end
  end

  // Trace sequencing: idle, packing, draining, ended.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (test_ending)  w_state_d = StDrain;
        else if (trc_on)  w_state_d = StRun;
      end
      StRun: begin
        if (test_ending)  w_state_d = StDrain;
        else if (!trc_on) w_state_d = StIdle;
      end
      StDrain: begin
        // Judged on next-state values so completion shows the cycle after the last accept.
        if ((w_cnt_d == '0) && !w_out_valid_d) w_state_d = StEnded;
      end
      StEnded: w_state_d = StEnded;
      default: w_state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= StIdle;
      r_buf        <= '0;
      r_cnt        <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_overflow   <= 1'b0;
      r_flush_pend <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_buf        <= w_buf_d;
      r_cnt        <= w_cnt_d;
      r_out_valid  <= w_out_valid_d;
      r_out_data   <= w_out_data_d;
      r_overflow   <= w_overflow_d;
      r_flush_pend <= w_flush_pend_d;
    end
  end

  assign dct_buffer     = r_buf;
  assign dct_count      = r_cnt;
  assign out_valid      = r_out_valid;
  assign out_data       = r_out_data;
  assign overflow       = r_overflow;
  assign test_has_ended = (r_state == StEnded);

endmodule

// File: tb/tb_cpu_oci_dct_packer.sv
// Self-checking bench for cpu_oci_dct_packer: table-driven pack/flush vectors, a word
// scoreboard checked on every writer accept, and hand-written multi-cycle sequences.
module tb_cpu_oci_dct_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        trc_on;
  logic        code_valid;
  logic [1:0]  code;
  logic        flush_req;
  logic        test_ending;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        out_valid;
  logic        out_ready;
  logic [33:0] out_data;
  logic        overflow;
  logic        test_has_ended;

  int n_vec = 0;
  int n_err = 0;
  logic [33:0] sb[$];

  cpu_oci_dct_packer #(.CODE_W(2), .SLOTS(15)) dut (
    .clk            (clk),
    .reset          (reset),
    .trc_on         (trc_on),
    .code_valid     (code_valid),
    .code           (code),
    .flush_req      (flush_req),
    .test_ending    (test_ending),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .overflow       (overflow),
    .test_has_ended (test_has_ended)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference packing: oldest code ends up in the highest occupied slot.
  function automatic logic [33:0] pack(input int n, input logic [31:0] codes);
    logic [29:0] w = '0;
    for (int i = 0; i < n; i++) w = {w[27:0], codes[2*i +: 2]};
    return {4'(n), w};
  endfunction

  // Scoreboard: every word the writer accepts must match the oldest expected word.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_word: got %h, expected none", out_data);
      end else begin
        chk("word", out_data, sb.pop_front());
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_code(input logic [1:0] c);
    code_valid = 1'b1;
    code       = c;
    cycles(1);
    code_valid = 1'b0;
  endtask

  task automatic send_codes(input int n, input logic [31:0] codes);
    for (int i = 0; i < n; i++) send_code(codes[2*i +: 2]);
  endtask

  task automatic pulse_flush();
    flush_req = 1'b1;
    cycles(1);
    flush_req = 1'b0;
  endtask

  // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    chk("rst_buffer", 34'(dct_buffer), 34'h0);
    chk("rst_count", 34'(dct_count), 34'h0);
    chk("rst_valid", 34'(out_valid), 34'h0);
    chk("rst_data", out_data, 34'h0);
    chk("rst_overflow", 34'(overflow), 34'h0);
    chk("rst_ended", 34'(test_has_ended), 34'h0);
    trc_on = 1'b0; code_valid = 1'b0; code = 2'b00; flush_req = 1'b0;
    test_ending = 1'b0; out_ready = 1'b1;
    sb.delete();
    cycles(1);
    reset = 1'b0;
    trc_on = 1'b1;
    cycles(1);
  endtask

  typedef struct {
    int          n;
    logic [31:0] codes;
    int          exp_words;
    logic [3:0]  exp_cnt;
  } vec_t;

  vec_t vt[5];

  initial begin
    reset = 1'b1; trc_on = 1'b0; code_valid = 1'b0; code = 2'b00;
    flush_req = 1'b0; test_ending = 1'b0; out_ready = 1'b1;

    vt[0] = '{1,  32'h0000_0003, 1, 4'd0};
    vt[1] = '{5,  32'h0000_01E4, 1, 4'd0};
    vt[2] = '{14, 32'h01B1_E4E4, 1, 4'd0};
    vt[3] = '{15, 32'h5555_5555, 1, 4'd0};
    vt[4] = '{0,  32'h0000_0000, 0, 4'd0};

    cycles(2);
    do_reset();

    // Table: pack n codes, then flush; full buffers emit on their own.
    for (int v = 0; v < 5; v++) begin
      if (vt[v].exp_words == 1) sb.push_back(pack(vt[v].n, vt[v].codes));
      send_codes(vt[v].n, vt[v].codes);
      if (vt[v].n == 15) begin
        chk("full_latency_valid", 34'(out_valid), 34'h1);
        chk("full_count_zero", 34'(dct_count), 34'h0);
      end
      pulse_flush();
      cycles(3);
      chk("tbl_count", 34'(dct_count), 34'(vt[v].exp_cnt));
      chk("tbl_sb_empty", 34'(sb.size()), 34'h0);
    end

    // Code and flush in the same cycle at count 7: new code lands in slot 0 of an 8-word.
    sb.push_back(pack(8, 32'h0000_E4E4));
    send_codes(7, 32'h0000_E4E4);
    code_valid = 1'b1; code = 2'b11; flush_req = 1'b1;
    cycles(1);
    code_valid = 1'b0; flush_req = 1'b0;
    chk("cflush_valid", 34'(out_valid), 34'h1);
    cycles(2);
    chk("cflush_sb_empty", 34'(sb.size()), 34'h0);

    // Back-pressure: held word stays stable, second buffer fills, 31st code is dropped.
    out_ready = 1'b0;
    sb.push_back(pack(15, 32'h5555_5555));
    sb.push_back(pack(15, 32'hAAAA_AAAA));
    send_codes(15, 32'h5555_5555);
    for (int i = 0; i < 15; i++) begin
      send_code(2'b10);
      chk("hold_stable", out_data, pack(15, 32'h5555_5555));
    end
    chk("bp_count_full", 34'(dct_count), 34'hF);
    chk("bp_no_overflow", 34'(overflow), 34'h0);
    send_code(2'b11);
    chk("ovf_set", 34'(overflow), 34'h1);
    chk("ovf_count", 34'(dct_count), 34'hF);
    chk("ovf_buffer", 34'(dct_buffer), 34'h2AAA_AAAA);
    out_ready = 1'b1;
    cycles(1);
    chk("bp_second_valid", 34'(out_valid), 34'h1);
    cycles(2);
    chk("bp_sb_empty", 34'(sb.size()), 34'h0);
    chk("ovf_sticky", 34'(overflow), 34'h1);
    do_reset();

    // Flush requests while the holding register is busy pend and collapse into one word.
    out_ready = 1'b0;
    sb.push_back(pack(15, 32'h5555_5555));
    sb.push_back(pack(3, 32'h0000_0039));
    send_codes(15, 32'h5555_5555);
    send_codes(3, 32'h0000_0039);
    pulse_flush();
    cycles(1);
    pulse_flush();
    chk("pend_count", 34'(dct_count), 34'h3);
    out_ready = 1'b1;
    cycles(4);
    chk("pend_sb_empty", 34'(sb.size()), 34'h0);
    chk("pend_count_zero", 34'(dct_count), 34'h0);
    do_reset();

    // End of test: partial word drains, completion shows the cycle after its accept.
    sb.push_back(pack(3, 32'h0000_0036));
    send_codes(3, 32'h0000_0036);
    test_ending = 1'b1;
    cycles(1);
    chk("drain_valid", 34'(out_valid), 34'h1);
    chk("drain_not_ended", 34'(test_has_ended), 34'h0);
    cycles(1);
    chk("drain_ended", 34'(test_has_ended), 34'h1);
    send_codes(2, 32'h0000_0005);
    chk("ended_ignores_codes", 34'(dct_count), 34'h0);
    chk("ended_no_word", 34'(out_valid), 34'h0);
    chk("ended_sb_empty", 34'(sb.size()), 34'h0);
    do_reset();

    // Reset while a word is held and 9 codes are packed.
    out_ready = 1'b0;
    send_codes(15, 32'h5555_5555);
    send_codes(9, 32'h0001_B1E4);
    chk("pre_rst_valid", 34'(out_valid), 34'h1);
    chk("pre_rst_count", 34'(dct_count), 34'h9);
    do_reset();
    send_codes(2, 32'h0000_0005);
    chk("post_rst_count", 34'(dct_count), 34'h2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
